// File: rtl/pcm_playback.sv
// PCM sample player: fetches one FIFO word per sample period and renders it as
// single-bit PWM, counting periods that end with nothing to play.
module pcm_playback #(
  parameter int dat_width  = 18,
  parameter int pcm_width  = 8,
  parameter int sample_div = 3125
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr_stat,
  input  logic                 fifo_empty,
  input  logic [dat_width-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 pwm_out,
  output logic [pcm_width-1:0] sample_out,
  output logic                 sample_strobe,
  output logic                 underrun,
  output logic [7:0]           underrun_cnt,
  output logic                 busy
);

  localparam int cnt_w = $clog2(sample_div);
  localparam logic [cnt_w-1:0]     cnt_reload = cnt_w'(sample_div - 1);
  localparam logic [pcm_width-1:0] midscale   = pcm_width'(1 << (pcm_width - 1));

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t               state, state_next;
  logic                 fetch, starve, leaving;
  logic [cnt_w-1:0]     sample_cnt;
  logic [pcm_width-1:0] pwm_cnt;

  if (dat_width > pcm_width) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^fifo_data[dat_width-1:pcm_width];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // en=0 wins over a coincident fetch or underrun, so those decodes sit below it.
  always_comb begin
    state_next = state;
    fetch      = 1'b0;
    starve     = 1'b0;
    unique case (state)
      IDLE: if (en) state_next = PRIME;
      PRIME: begin
        if (!en) state_next = IDLE;
        else if (!fifo_empty) begin
          fetch      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!en) state_next = IDLE;
        else if (sample_cnt == '0) begin
          fetch  = !fifo_empty;
          starve = fifo_empty;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    leaving = (state != IDLE) && (state_next == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_rd       <= 1'b0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      pwm_out       <= 1'b0;
      sample_out    <= midscale;
      sample_cnt    <= '0;
      pwm_cnt       <= '0;
      underrun_cnt  <= '0;
    end else begin
      fifo_rd       <= fetch;
      sample_strobe <= fetch;
      underrun      <= starve;
      pwm_out       <= (state == RUN) && en && (pwm_cnt < sample_out);

      if (leaving) begin
        sample_out <= midscale;
        sample_cnt <= '0;
        pwm_cnt    <= '0;
      end else begin
        if (fetch) begin
          sample_out <= fifo_data[pcm_width-1:0];
          sample_cnt <= cnt_reload;
        end else if (starve) begin
          sample_cnt <= cnt_reload;
        end else if (state == RUN) begin
          sample_cnt <= sample_cnt - 1'b1;
        end

        if (state == PRIME)    pwm_cnt <= '0;
        else if (state == RUN) pwm_cnt <= pwm_cnt + 1'b1;
      end

      if (clr_stat)                       underrun_cnt <= '0;
      else if (starve && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pcm_playback.sv
// Bench for pcm_playback: table-driven start-up, directed corner sequences and
// randomized traffic, all checked against a period/age-based playback model.
module tb_pcm_playback;

  localparam int DW  = 18;
  localparam int PW  = 8;
  localparam int DIV = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          clr_stat = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd, pwm_out, sample_strobe, underrun, busy;
  logic [PW-1:0] sample_out;
  logic [7:0]    underrun_cnt;

  pcm_playback #(.dat_width(DW), .pcm_width(PW), .sample_div(DIV)) dut (
    .clk(clk), .reset(reset), .en(en), .clr_stat(clr_stat),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .pwm_out(pwm_out), .sample_out(sample_out), .sample_strobe(sample_strobe),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, playback described by mode, position in the
  // current sample period and number of clocks spent playing.
  logic [DW-1:0] q[$];
  int  m_mode;   // 0 stopped, 1 waiting for first word, 2 playing
  int  m_phase;  // clocks elapsed in the current sample period
  int  m_age;    // clocks played since playback started
  int  m_sample, m_ucnt;
  bit  m_rd, m_strobe, m_under, m_pwm, pop_due;

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_age = 0; m_sample = 128; m_ucnt = 0;
    m_rd = 0; m_strobe = 0; m_under = 0; m_pwm = 0; pop_due = 0;
  endtask

  task automatic model_edge(input bit e, input bit c);
    bit empty;
    bit n_rd, n_un, n_pwm;
    empty = (q.size() == 0);
    n_rd = 0; n_un = 0; n_pwm = 0;
    pop_due = m_rd;
    if (m_mode == 0) begin
      if (e) m_mode = 1;
    end else if (!e) begin
      m_mode = 0; m_sample = 128; m_phase = 0; m_age = 0;
    end else if (m_mode == 1) begin
      if (!empty) begin
        n_rd = 1; m_sample = int'(q[0][PW-1:0]);
        m_mode = 2; m_phase = 0; m_age = 0;
      end
    end else begin
      n_pwm = ((m_age % 256) < m_sample);
      m_age++;
      if (m_phase == DIV - 1) begin
        m_phase = 0;
        if (!empty) begin n_rd = 1; m_sample = int'(q[0][PW-1:0]); end
        else n_un = 1;
      end else m_phase++;
    end
    if (c) m_ucnt = 0;
    else if (n_un && m_ucnt < 255) m_ucnt++;
    m_rd = n_rd; m_strobe = n_rd; m_under = n_un; m_pwm = n_pwm;
  endtask

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = fifo_empty ? DW'($urandom) : q[0];
  endtask

  task automatic step(input bit e, input bit c);
    en = e; clr_stat = c;
    drive_fifo();
    model_edge(e, c);
    @(negedge clk);
    if (pop_due && q.size() > 0) void'(q.pop_front());
    cyc++;
    check("outputs",
          {busy, fifo_rd, sample_strobe, underrun, pwm_out, sample_out, underrun_cnt},
          {1'(m_mode != 0), m_rd, m_strobe, m_under, m_pwm, 8'(m_sample), 8'(m_ucnt)});
  endtask

  task automatic do_reset();
    reset = 1; en = 0; clr_stat = 0;
    q.delete();
    drive_fifo();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    check("reset_state",
          {busy, fifo_rd, sample_strobe, underrun, pwm_out, sample_out, underrun_cnt},
          {5'b0, 8'h80, 8'h00});
  endtask

  typedef struct {
    bit en; bit push; logic [7:0] data;
    bit busy; bit rd; bit strobe; bit pwm; logic [7:0] sample;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   highs;
    int   rd_t[$];
    int   un_c[$];
    logic [7:0] st_v[$];
    bit   pushed, seen;
    int   nrd;
    int   exp_gap[3];
    logic [7:0] exp_st[4];

    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80};
    tbl[1] = '{1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h40};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40};
    exp_gap = '{8, 8, 32};
    exp_st  = '{8'h10, 8'h20, 8'h30, 8'h40};

    // Start-up from reset and PWM duty for sample 0x40.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].push) q.push_back({10'h2A5, tbl[i].data});
      step(tbl[i].en, 1'b0);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("tbl%0d_rd", i), fifo_rd, tbl[i].rd);
      check($sformatf("tbl%0d_strobe", i), sample_strobe, tbl[i].strobe);
      check($sformatf("tbl%0d_pwm", i), pwm_out, tbl[i].pwm);
      check($sformatf("tbl%0d_sample", i), sample_out, tbl[i].sample);
    end
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0);
      if (pwm_out) highs++;
    end
    check("duty_0x40", highs, 64);

    // Steady stream, underrun with hold, then resume on a late write.
    do_reset();
    q.push_back({10'h155, 8'h10});
    q.push_back({10'h0F0, 8'h20});
    q.push_back({10'h3FF, 8'h30});
    pushed = 0;
    for (int i = 0; i < 60; i++) begin
      if (un_c.size() == 3 && !pushed) begin
        q.push_back({10'h001, 8'h40});
        pushed = 1;
      end
      step(1'b1, 1'b0);
      if (fifo_rd) rd_t.push_back(cyc);
      if (sample_strobe) st_v.push_back(sample_out);
      if (underrun) begin
        un_c.push_back(int'(underrun_cnt));
        check("hold_on_underrun", sample_out, (un_c.size() <= 3) ? 8'h30 : 8'h40);
      end
    end
    check("stream_pop_count", rd_t.size(), 4);
    check("stream_strobe_count", st_v.size(), 4);
    if (rd_t.size() == 4)
      for (int k = 1; k < 4; k++) check($sformatf("pop_gap%0d", k), rd_t[k] - rd_t[k-1], exp_gap[k-1]);
    if (st_v.size() == 4)
      for (int k = 0; k < 4; k++) check($sformatf("stream_sample%0d", k), st_v[k], exp_st[k]);
    check("underrun_pulses", (un_c.size() >= 3), 1);
    if (un_c.size() >= 3)
      for (int k = 0; k < 3; k++) check($sformatf("underrun_cnt%0d", k), un_c[k], k + 1);

    // Saturation, clear, and clear coincident with an underrun.
    do_reset();
    q.push_back(18'h00077);
    for (int i = 0; i < 2420; i++) step(1'b1, 1'b0);
    check("cnt_saturated", underrun_cnt, 8'd255);
    step(1'b1, 1'b1);
    check("cnt_cleared", underrun_cnt, 8'd0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, 1'b0);
      seen = underrun;
    end
    check("underrun_seen", seen, 1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    check("cnt_before_coincident", underrun_cnt, 8'd1);
    step(1'b1, 1'b1);
    check("coincident_underrun", underrun, 1);
    check("coincident_clear", underrun_cnt, 8'd0);

    // en falls on the very edge a fetch would happen with data waiting.
    q.push_back({10'h2AA, 8'h5A});
    for (int i = 0; i < 20 && !(m_mode == 2 && m_phase == DIV - 1); i++) step(1'b1, 1'b0);
    check("at_boundary", (m_mode == 2 && m_phase == DIV - 1), 1);
    step(1'b0, 1'b0);
    check("dis_rd", fifo_rd, 0);
    check("dis_strobe", sample_strobe, 0);
    check("dis_pwm", pwm_out, 0);
    check("dis_sample", sample_out, 8'h80);
    check("dis_busy", busy, 0);
    step(1'b0, 1'b0);
    check("dis_rd_after", fifo_rd, 0);

    // Asynchronous reset while a pop strobe is high.
    do_reset();
    q.push_back({10'h000, 8'h11});
    q.push_back({10'h000, 8'h22});
    q.push_back({10'h000, 8'h33});
    nrd = 0;
    for (int i = 0; i < 40 && nrd < 2; i++) begin
      step(1'b1, 1'b0);
      if (fifo_rd) nrd++;
    end
    check("second_pop_seen", nrd, 2);
    #2 reset = 1;
    #1 check("async_reset_outputs",
             {busy, fifo_rd, sample_strobe, underrun, pwm_out, sample_out, underrun_cnt},
             {5'b0, 8'h80, 8'h00});
    @(negedge clk);
    reset = 0;
    model_reset();
    step(1'b1, 1'b0);
    check("post_reset_prime_rd", fifo_rd, 0);
    check("post_reset_prime_busy", busy, 1);
    step(1'b1, 1'b0);
    check("post_reset_fetch_rd", fifo_rd, 1);
    check("post_reset_fetch_sample", sample_out, 8'h22);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 20 && q.size() < 16) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        case ($urandom_range(0, 3))
          0: w[7:0] = 8'h00;
          1: w[7:0] = 8'hFF;
          default: ;
        endcase
        q.push_back(w);
      end
      step($urandom_range(0, 99) < 97, $urandom_range(0, 49) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pcm_playback.md
PCM_PLAYBACK -- requirements
Module: pcm_playback

Interface
REQ-001 Parameter dat_width, default 18: FIFO word width.
REQ-002 Parameter pcm_width, default 8: PCM sample width and PWM resolution; only fifo_data[pcm_width-1:0] is used.
REQ-003 Parameter sample_div, default 3125: clk cycles per sample period; legal range is 2 or more.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  playback enable, level-sensitive.
REQ-007 clr_stat  input  1  synchronous clear of underrun_cnt.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_data  input  dat_width  FIFO head word, first-word-fall-through, valid whenever fifo_empty=0.
REQ-010 fifo_rd  output  1  registered one-cycle pop strobe to the FIFO.
REQ-011 pwm_out  output  1  registered PWM audio output.
REQ-012 sample_out  output  pcm_width  currently playing sample.
REQ-013 sample_strobe  output  1  one-cycle pulse on every successful fetch.
REQ-014 underrun  output  1  one-cycle pulse when a sample period ends with the FIFO empty.
REQ-015 underrun_cnt  output  8  count of underruns, saturating at 255.
REQ-016 busy  output  1  high in states PRIME and RUN.

Function
REQ-017 The state machine SHALL have three states: IDLE, PRIME and RUN.
REQ-018 IDLE SHALL go to PRIME on an edge with en=1, otherwise stay in IDLE.
REQ-019 In PRIME, an edge with en=1 and fifo_empty=0 SHALL perform a fetch and go to RUN, so playback never starts on an underrun.
REQ-020 A fetch SHALL load sample_out with fifo_data[pcm_width-1:0], set fifo_rd=1 and sample_strobe=1 for the next single cycle, and load sample_cnt with sample_div-1.
REQ-021 In RUN, sample_cnt SHALL decrement by 1 per clk; at sample_cnt=0 the edge either fetches (fifo_empty=0) or underruns (fifo_empty=1).
REQ-022 An underrun SHALL hold the previous sample_out, pulse underrun for one cycle, increment underrun_cnt unless it is 255, and reload sample_cnt with sample_div-1.
REQ-023 fifo_rd SHALL never be high on two consecutive cycles; at most one pop per sample period (guaranteed by sample_div of 2 or more).
REQ-024 A fetch decision SHALL use only fifo_empty sampled on that edge; no pop while fifo_empty=1.
REQ-025 pwm_cnt (pcm_width bits) SHALL clear to 0 on the PRIME-to-RUN edge, then increment every clk in RUN, wrapping from 2^pcm_width-1 to 0.
REQ-026 In RUN, pwm_out SHALL be registered as (pwm_cnt < sample_out), unsigned; sample 0 gives a constant 0, and sample 255 gives high for 255 of every 256 clocks.
REQ-027 pwm_out SHALL be 0 in IDLE and PRIME.
REQ-028 An edge with en=0 in PRIME or RUN SHALL go to IDLE.
- en=0 has priority over a simultaneous fetch or underrun: no pop, no strobe, no count.
REQ-029 On entry to IDLE, sample_out SHALL load midscale 2^(pcm_width-1), and sample_cnt and pwm_cnt SHALL clear.
REQ-030 A fifo_rd pulse already registered when en falls SHALL still complete its single cycle.
REQ-031 clr_stat=1 SHALL clear underrun_cnt at the edge in any state.
- clr_stat takes priority over a simultaneous increment.
REQ-032 underrun_cnt SHALL be retained across IDLE.

Reset
REQ-033 While reset=1, the block SHALL asynchronously enter IDLE with these values:
- fifo_rd=0, pwm_out=0, sample_strobe=0, underrun=0, busy=0
- underrun_cnt=0, sample_cnt=0, pwm_cnt=0
- sample_out=2^(pcm_width-1) (0x80 at default)
REQ-034 Reset asserted mid-RUN SHALL abort immediately with no further fifo_rd pulse.
REQ-035 After reset deassertion, the first possible fifo_rd SHALL be two edges later: IDLE to PRIME, then the fetch.

Verification
REQ-036 Start-up: sample_div=8; en=1 with FIFO holding 0x0040 -> busy=1 on the next edge; fetch on the second edge; fifo_rd and sample_strobe high for exactly 1 cycle; sample_out=0x40; pwm_out high 64 of every 256 clocks.
REQ-037 Steady stream: 4 words 0x10, 0x20, 0x30, 0x40 preloaded, sample_div=8 -> fifo_rd pulses exactly 8 clks apart; sample_out steps through those values; no underrun.
REQ-038 Underrun: FIFO empties after 0x30 -> underrun pulses every 8 clks; sample_out holds 0x30; underrun_cnt counts 1, 2, 3; a later write resumes fetching at the next sample boundary.
REQ-039 Saturation and clear: 300 consecutive underruns -> underrun_cnt=255; clr_stat=1 for one clk -> 0; clr_stat coincident with an underrun -> 0.
REQ-040 Disable mid-run: en=0 on the same edge as sample_cnt=0 with FIFO non-empty -> no fifo_rd pulse; pwm_out=0; sample_out=0x80; busy=0 at that edge.
REQ-041 Reset mid-run: reset pulse during RUN -> all outputs at their REQ-033 values within the same cycle; FIFO occupancy unchanged.
